zero_check_arbiter: RTL and testbench



---
 rtl/zero_check_arbiter.sv | 122 ++++++++++++
 tb/tb_zero_check_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/zero_check_arbiter.sv
// Round-robin arbiter sharing one 16-bit NOR zero detector among four requesters.
// The granted requester's operands are latched, evaluated, and returned with its id.

module nor16way (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out
);
  assign out = ~|(a | b);
endmodule

module zero_check_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic [1:0]             done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] op_a_r, op_b_r;
  logic [1:0]  id_r, ptr_r, done_id_r;
  logic        res_r, done_r, busy_r;
  logic [3:0]  gnt_r, gnt_s;
  logic [1:0]  win_s, idx_s;
  logic        hit_s;
  logic        nor_s;

  nor16way u_nor (
    .a   (op_a_r),
    .b   (op_b_r),
    .out (nor_s)
  );

  // Winner search from ptr and next-state decode
  always_comb begin
    state_s = state_r;
    gnt_s   = 4'b0000;
    win_s   = 2'd0;
    idx_s   = 2'd0;
    hit_s   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx_s = ptr_r + 2'(i);
      if (!hit_s && req[idx_s]) begin
        hit_s = 1'b1;
        win_s = idx_s;
      end else begin
        hit_s = hit_s;
      end
    end
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          state_s = EVAL;
          gnt_s   = 4'b0001 << win_s;
        end else begin
          state_s = IDLE;
        end
      end
      EVAL:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, captured operands, pointer and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      op_a_r    <= 16'h0000;
      op_b_r    <= 16'h0000;
      id_r      <= 2'd0;
      ptr_r     <= 2'd0;
      res_r     <= 1'b0;
      gnt_r     <= 4'b0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 2'd0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (hit_s) begin
            op_a_r <= a_in[{win_s, 4'b0000} +: 16];
            op_b_r <= b_in[{win_s, 4'b0000} +: 16];
            id_r   <= win_s;
          end
        end
        EVAL: begin
          res_r     <= nor_s;
          done_id_r <= id_r;
        end
        DONE:    ptr_r <= id_r + 2'd1;
        default: ptr_r <= ptr_r;
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = res_r;
  assign done_id = done_id_r;

endmodule

// File: tb/tb_zero_check_arbiter.sv
// Directed plus randomized bench for zero_check_arbiter against a transaction-level
// round-robin model.

module tb_zero_check_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] a_in, b_in;
  logic [3:0]  gnt;
  logic        busy, done, result;
  logic [1:0]  done_id;

  int n_assert = 0;
  int n_fail   = 0;
  int ptr_m    = 0;

  zero_check_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; the DUT must be in IDLE when this is called.
  task automatic do_txn(input logic [3:0] r, input logic [63:0] a, input logic [63:0] b,
                        input bit drop, input bit mutate);
    int w;
    logic [15:0] ea, eb;
    logic exp_res;
    w = -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr_m + i) % 4;
      if (w < 0 && r[j]) w = j;
    end
    ea = a[w*16 +: 16];
    eb = b[w*16 +: 16];
    exp_res = ((ea | eb) == 16'h0000);
    req  = r;
    a_in = a;
    b_in = b;
    @(posedge clk); #1;
    chk("gnt", 16'(gnt), 16'(4'b0001 << w));
    chk("busy_gnt", 16'(busy), 16'd1);
    chk("done_gnt", 16'(done), 16'd0);
    if (drop) req = 4'b0000;
    if (mutate) begin
      a_in = ~a_in;
      b_in = ~b_in;
    end
    @(posedge clk); #1;
    chk("done", 16'(done), 16'd1);
    chk("result", 16'(result), 16'(exp_res));
    chk("done_id", 16'(done_id), 16'(w));
    chk("gnt_done", 16'(gnt), 16'd0);
    chk("busy_done", 16'(busy), 16'd1);
    @(posedge clk); #1;
    chk("done_idle", 16'(done), 16'd0);
    chk("busy_idle", 16'(busy), 16'd0);
    chk("gnt_idle", 16'(gnt), 16'd0);
    chk("result_hold", 16'(result), 16'(exp_res));
    chk("done_id_hold", 16'(done_id), 16'(w));
    ptr_m = (w + 1) % 4;
  endtask

  function automatic logic [15:0] rand_op(input int mode);
    logic [15:0] v;
    case (mode)
      0:       v = 16'h0000;
      1:       v = 16'h0001 << $urandom_range(15, 0);
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] ra, rb;
    logic [3:0]  rr;
    rst_n = 1'b0;
    req   = 4'b1111;
    a_in  = 64'h0;
    b_in  = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 16'(gnt), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_result", 16'(result), 16'd0);
    chk("rst_done_id", 16'(done_id), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;

    // All requesters held: strict rotation 0,1,2,3,0
    for (int t = 0; t < 5; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_txn(4'b1111, ra, rb, 1'b0, 1'b0);
    end

    // Requester 2 all-zero operands
    do_txn(4'b0100, 64'h0, 64'h0, 1'b1, 1'b0);
    // Single-bit edges on requester 0: bit 15 then bit 0
    do_txn(4'b0001, 64'h0, 64'h0000_0000_0000_8000, 1'b1, 1'b0);
    do_txn(4'b0001, 64'h0000_0000_0000_0001, 64'h0, 1'b1, 1'b0);
    // Pointer wrap after requester 3
    do_txn(4'b1000, 64'hFFFF_0000_0000_0000, 64'h0, 1'b1, 1'b0);
    do_txn(4'b1001, 64'h0, 64'h0, 1'b1, 1'b0);
    // Operands changed after grant must not affect the result
    do_txn(4'b0010, 64'h0, 64'h0, 1'b1, 1'b1);

    // Reset during EVAL aborts the transaction and clears the pointer
    do_txn(4'b0100, 64'h0, 64'h0, 1'b1, 1'b0);
    req = 4'b1000;
    @(posedge clk); #1;
    chk("abort_gnt", 16'(gnt), 16'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_gnt0", 16'(gnt), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    req = 4'b0000;
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", 16'(done), 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    do_txn(4'b1001, 64'h0, 64'h0, 1'b1, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      rr = 4'($urandom_range(15, 1));
      for (int i = 0; i < 4; i++) begin
        int m;
        m = $urandom_range(3, 0);
        ra[i*16 +: 16] = rand_op(m);
        rb[i*16 +: 16] = rand_op((m == 0) ? 0 : int'($urandom_range(2, 0)));
      end
      do_txn(rr, ra, rb, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
